// File: rtl/skid_buffer_if.sv
// skid_buffer_if: valid/ready handshake bundle around a skid_buffer.
//   In*  : upstream producer -> buffer (InValid, InData) and back (InReady)
//   Out* : buffer -> downstream reader (OutValid, OutData) and back (OutReady)
// Modports:
//   slave  - the buffer itself
//   master - the environment driving/consuming the buffer
interface skid_buffer_if #(
  parameter int WID_DATA = 32
);
  logic                InValid;
  logic                InReady;
  logic [WID_DATA-1:0] InData;
  logic                OutValid;
  logic                OutReady;
  logic [WID_DATA-1:0] OutData;

  modport slave (
    input  InValid, InData, OutReady,
    output InReady, OutValid, OutData
  );

  modport master (
    output InValid, InData, OutReady,
    input  InReady, OutValid, OutData
  );
endinterface

// File: rtl/skid_buffer.sv
// skid_buffer: two-entry valid/ready buffer (head + skid register).
// Every output is a flop, so InReady never depends combinationally on
// OutReady.
// Ports:
//   Clock       rising-edge clock
//   Reset_n     asynchronous active-low reset
//   Flush       synchronous discard of all buffered words (highest priority)
//   bus         skid_buffer_if.slave handshake bundle
//   StallCount  cycles with OutValid=1 & OutReady=0, saturating
//               (only when SKID_BUFFER_STALL_CNT_EN is defined)
// Optional feature macro: SKID_BUFFER_STALL_CNT_EN
module skid_buffer #(
  parameter int WID_DATA      = 32,
  parameter int WID_STALL_CNT = 16
) (
  input  logic                     Clock,
  input  logic                     Reset_n,
  input  logic                     Flush,
`ifdef SKID_BUFFER_STALL_CNT_EN
  output logic [WID_STALL_CNT-1:0] StallCount,
`endif
  skid_buffer_if.slave             bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t              state;
  logic                outValidQ;
  logic                inReadyQ;
  logic [WID_DATA-1:0] headQ;
  logic [WID_DATA-1:0] skidQ;
  logic                accept;
  logic                pop;

  if (WID_STALL_CNT < 1) begin : gBadStallWidth
    $error("skid_buffer: WID_STALL_CNT must be at least 1");
  end

  // Handshakes use the registered flags, never the raw state decode.
  assign accept = bus.InValid & inReadyQ;
  assign pop    = outValidQ & bus.OutReady;

  assign bus.InReady  = inReadyQ;
  assign bus.OutValid = outValidQ;
  assign bus.OutData  = headQ;

  // Flags are registered together with the state so they always match it:
  // OutValid = (state != EMPTY), InReady = (state != FULL).
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= EMPTY;
      outValidQ <= 1'b0;
      inReadyQ  <= 1'b1;
      headQ     <= '0;
      skidQ     <= '0;
    end else if (Flush) begin
      // Same-cycle accept/pop are dropped; payload registers keep stale data.
      state     <= EMPTY;
      outValidQ <= 1'b0;
      inReadyQ  <= 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state     <= ONE;
            outValidQ <= 1'b1;
            headQ     <= bus.InData;
          end
        end
        ONE: begin
          if (accept && pop) begin
            headQ <= bus.InData;
          end else if (accept) begin
            state    <= FULL;
            inReadyQ <= 1'b0;
            skidQ    <= bus.InData;
          end else if (pop) begin
            state     <= EMPTY;
            outValidQ <= 1'b0;
          end
        end
        FULL: begin
          // InReady is low here, so no accept can happen.
          if (pop) begin
            state    <= ONE;
            inReadyQ <= 1'b1;
            headQ    <= skidQ;
          end
        end
        default: begin
          state     <= EMPTY;
          outValidQ <= 1'b0;
          inReadyQ  <= 1'b1;
        end
      endcase
    end
  end

`ifdef SKID_BUFFER_STALL_CNT_EN
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      StallCount <= '0;
    end else if (Flush) begin
      StallCount <= '0;
    end else if (outValidQ && !bus.OutReady && (StallCount != '1)) begin
      StallCount <= StallCount + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_skid_buffer.sv
// tb_skid_buffer: directed bench for skid_buffer. A queue model of the
// buffer contents predicts OutValid/InReady/OutData (and StallCount when
// SKID_BUFFER_STALL_CNT_EN is defined) every cycle; literal checks pin the
// model on the hand-worked scenarios.
module tb_skid_buffer;
  localparam int WD  = 32;
  localparam int WSC = 4;
  localparam int SAT = (1 << WSC) - 1;

  logic Clock = 1'b0;
  logic Reset_n;
  logic Flush;
`ifdef SKID_BUFFER_STALL_CNT_EN
  logic [WSC-1:0] StallCount;
`endif

  skid_buffer_if #(.WID_DATA(WD)) bus ();

  skid_buffer #(.WID_DATA(WD), .WID_STALL_CNT(WSC)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Flush      (Flush),
`ifdef SKID_BUFFER_STALL_CNT_EN
    .StallCount (StallCount),
`endif
    .bus        (bus)
  );

  always #5 Clock = ~Clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: contents as a FIFO of at most two words; popped words are logged.
  logic [WD-1:0] mq[$];
  logic [WD-1:0] delivered[$];
  int            mN;
  int            mStall;

  always @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      mq.delete();
      mStall = 0;
    end else if (Flush) begin
      mq.delete();
      mStall = 0;
    end else begin
      mN = mq.size();
      if (mN > 0 && !bus.OutReady && mStall < SAT) mStall++;
      if (mN > 0 && bus.OutReady) delivered.push_back(mq.pop_front());
      if (bus.InValid && mN < 2) mq.push_back(bus.InData);
    end
  end

  always @(negedge Clock) begin
    if (Reset_n === 1'b1) begin
      chk("cyc_OutValid", {63'd0, bus.OutValid}, {63'd0, mq.size() > 0});
      chk("cyc_InReady", {63'd0, bus.InReady}, {63'd0, mq.size() < 2});
      if (mq.size() > 0) chk("cyc_OutData", 64'(bus.OutData), 64'(mq[0]));
`ifdef SKID_BUFFER_STALL_CNT_EN
      chk("cyc_StallCount", 64'(StallCount), 64'(mStall));
`endif
    end
  end

  // One clock of stimulus; returns just after the following falling edge.
  task automatic cyc(input logic iv, input logic [WD-1:0] d, input logic ordy, input logic fl);
    bus.InValid  = iv;
    bus.InData   = d;
    bus.OutReady = ordy;
    Flush        = fl;
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    Reset_n      = 1'b0;
    Flush        = 1'b0;
    bus.InValid  = 1'b0;
    bus.InData   = '0;
    bus.OutReady = 1'b0;
    repeat (2) @(negedge Clock);
    chk("rst_OutValid", {63'd0, bus.OutValid}, 64'd0);
    chk("rst_InReady", {63'd0, bus.InReady}, 64'd1);
    chk("rst_OutData", 64'(bus.OutData), 64'd0);
`ifdef SKID_BUFFER_STALL_CNT_EN
    chk("rst_StallCount", 64'(StallCount), 64'd0);
`endif
    Reset_n = 1'b1;

    // Single word, latency one cycle.
    cyc(1'b1, 32'hA5A5_0001, 1'b0, 1'b0);
    chk("one_OutValid", {63'd0, bus.OutValid}, 64'd1);
    chk("one_OutData", 64'(bus.OutData), 64'hA5A5_0001);
    chk("one_InReady", {63'd0, bus.InReady}, 64'd1);
    cyc(1'b0, '0, 1'b1, 1'b0);
    chk("one_drained", {63'd0, bus.OutValid}, 64'd0);

    // Streaming 1..8 at full rate.
    delivered.delete();
    for (int i = 1; i <= 8; i++) begin
      cyc(1'b1, WD'(i), 1'b1, 1'b0);
      chk("stream_InReady", {63'd0, bus.InReady}, 64'd1);
      chk("stream_OutData", 64'(bus.OutData), 64'(i));
    end
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("stream_count", 64'(delivered.size()), 64'd8);
    for (int i = 0; i < delivered.size(); i++) chk("stream_order", 64'(delivered[i]), 64'(i + 1));

    // Backpressure: fill head and skid, third word held upstream.
    delivered.delete();
    cyc(1'b1, 32'h10, 1'b0, 1'b0);
    cyc(1'b1, 32'h11, 1'b0, 1'b0);
    chk("bp_InReady_full", {63'd0, bus.InReady}, 64'd0);
    chk("bp_head", 64'(bus.OutData), 64'h10);
    cyc(1'b1, 32'h12, 1'b0, 1'b0);
    chk("bp_head_stable", 64'(bus.OutData), 64'h10);
    cyc(1'b1, 32'h12, 1'b1, 1'b0);
    chk("bp_skid_to_head", 64'(bus.OutData), 64'h11);
    cyc(1'b1, 32'h12, 1'b1, 1'b0);
    chk("bp_third", 64'(bus.OutData), 64'h12);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("bp_count", 64'(delivered.size()), 64'd3);
    if (delivered.size() == 3) begin
      chk("bp_order0", 64'(delivered[0]), 64'h10);
      chk("bp_order1", 64'(delivered[1]), 64'h11);
      chk("bp_order2", 64'(delivered[2]), 64'h12);
    end

    // Flush while FULL with OutReady=1: nothing popped.
    cyc(1'b1, 32'h30, 1'b0, 1'b0);
    cyc(1'b1, 32'h31, 1'b0, 1'b0);
    delivered.delete();
    cyc(1'b1, 32'h32, 1'b1, 1'b1);
    chk("fl_OutValid", {63'd0, bus.OutValid}, 64'd0);
    chk("fl_InReady", {63'd0, bus.InReady}, 64'd1);
    chk("fl_nopop", 64'(delivered.size()), 64'd0);
    cyc(1'b1, 32'h20, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, '0, 1'b1, 1'b0);
    chk("fl_next_count", 64'(delivered.size()), 64'd1);
    if (delivered.size() == 1) chk("fl_next_word", 64'(delivered[0]), 64'h20);

    // Stall counter saturation and flush clear.
    cyc(1'b1, 32'h40, 1'b0, 1'b0);
    repeat (20) cyc(1'b0, '0, 1'b0, 1'b0);
`ifdef SKID_BUFFER_STALL_CNT_EN
    chk("stall_sat", 64'(StallCount), 64'd15);
`endif
    cyc(1'b0, '0, 1'b0, 1'b1);
`ifdef SKID_BUFFER_STALL_CNT_EN
    chk("stall_flush", 64'(StallCount), 64'd0);
`endif
    chk("stall_flush_empty", {63'd0, bus.OutValid}, 64'd0);

    // Asynchronous reset between edges while FULL.
    cyc(1'b1, 32'h50, 1'b0, 1'b0);
    cyc(1'b1, 32'h51, 1'b0, 1'b0);
    chk("ar_full", {63'd0, bus.InReady}, 64'd0);
    bus.InValid  = 1'b0;
    bus.OutReady = 1'b0;
    @(posedge Clock);
    #2 Reset_n = 1'b0;
    #1;
    chk("ar_OutValid", {63'd0, bus.OutValid}, 64'd0);
    chk("ar_InReady", {63'd0, bus.InReady}, 64'd1);
    chk("ar_OutData", 64'(bus.OutData), 64'd0);
    #1 Reset_n = 1'b1;
    @(negedge Clock);
    cyc(1'b1, 32'h60, 1'b0, 1'b0);
    chk("ar_after", 64'(bus.OutData), 64'h60);
    cyc(1'b0, '0, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    errors++;
    $display("FAIL timeout: got running expected finished");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end
endmodule
